// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage datapath and the multi-cycle divider.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start_i;
    logic               signed_i;
    logic [WIDTH-1:0]   dividend_i;
    logic [WIDTH-1:0]   divisor_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    modport master (
        output start_i, signed_i, dividend_i, divisor_i, annul_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, signed_i, dividend_i, divisor_i, annul_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; returns {remainder, quotient} for HI/LO.
// Optional macro DIV_EARLY_ZERO_EN: a zero dividend finishes through the short BYZERO path.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BYZERO = 2'd1;
    localparam logic [1:0] S_ON     = 2'd2;
    localparam logic [1:0] S_END    = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic               sgnq_q, sgnq_d;
    logic               sgnr_q, sgnr_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH:0]     trial;
    logic               neg_a, neg_b, go_zero;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // Operand conditioning at acceptance: magnitudes plus result sign flags
    always_comb begin
        neg_a = bus.signed_i & bus.dividend_i[WIDTH-1];
        neg_b = bus.signed_i & bus.divisor_i[WIDTH-1];
        mag_a = neg_a ? WIDTH'(WIDTH'(0) - bus.dividend_i) : bus.dividend_i;
        mag_b = neg_b ? WIDTH'(WIDTH'(0) - bus.divisor_i) : bus.divisor_i;
`ifdef DIV_EARLY_ZERO_EN
        go_zero = (bus.divisor_i == '0) || (bus.dividend_i == '0);
`else
        go_zero = (bus.divisor_i == '0);
`endif
    end

    // Shifted partial remainder minus divisor; bit WIDTH set means the trial went negative
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        sgnq_d   = sgnq_q;
        sgnr_d   = sgnr_q;
        result_d = result_q;
        ready_d  = 1'b0;

        case (state_q)
            S_FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    rem_d   = '0;
                    quo_d   = mag_a;
                    dvsr_d  = mag_b;
                    sgnq_d  = neg_a ^ neg_b;
                    sgnr_d  = neg_a;
                    cnt_d   = '0;
                    state_d = go_zero ? S_BYZERO : S_ON;
                end
            end
            S_ON: begin
                if (bus.annul_i) begin
                    state_d = S_FREE;
                end else begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = CW'(cnt_q + CW'(1));
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                state_d = S_FREE;
                if (!bus.annul_i) begin
                    result_d = {sgnr_q ? WIDTH'(WIDTH'(0) - rem_q) : rem_q,
                                sgnq_q ? WIDTH'(WIDTH'(0) - quo_q) : quo_q};
                    ready_d  = 1'b1;
                end
            end
            S_BYZERO: begin
                state_d = S_FREE;
                if (!bus.annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            sgnq_q   <= 1'b0;
            sgnr_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            sgnq_q   <= sgnq_d;
            sgnr_q   <= sgnr_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
    assign bus.busy_o   = (state_q != S_FREE);
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random ops against an arithmetic model.
module tb_div_unit;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errs    = 0;
    logic [63:0] last_res;

    div_unit_if #(.WIDTH(WIDTH)) bus ();

    div_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division on 64-bit values (no overflow at INT_MIN/-1)
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
`ifdef DIV_EARLY_ZERO_EN
        if (a == 32'd0) return 1;
`endif
        return 33;
    endfunction

    // Issue one op from just after a rising edge; returns after ready_o is seen (#1 after edge)
    task automatic do_op(input string tag, input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int n;
        bit busy_ok;
        logic [63:0] exp;
        exp = ref_div(sgn, a, b);
        bus.start_i    = 1'b1;
        bus.signed_i   = sgn;
        bus.dividend_i = a;
        bus.divisor_i  = b;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        n = 0;
        busy_ok = 1'b1;
        while (n < 100) begin
            if (!bus.busy_o) busy_ok = 1'b0;
            if (n == 5) begin
                bus.start_i    = 1'b1;
                bus.dividend_i = $urandom;
                bus.divisor_i  = $urandom;
            end else begin
                bus.start_i = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (bus.ready_o) break;
        end
        bus.start_i = 1'b0;
        chk({tag, ".lat"}, 64'(n), 64'(exp_lat(a, b)));
        chk({tag, ".busy"}, 64'(busy_ok), 64'd1);
        chk({tag, ".res"}, bus.result_o, exp);
        last_res = exp;
    endtask

    initial begin
        rst            = 1'b1;
        bus.start_i    = 1'b0;
        bus.signed_i   = 1'b0;
        bus.dividend_i = '0;
        bus.divisor_i  = '0;
        bus.annul_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.res", bus.result_o, 64'd0);
        chk("reset.ready", 64'(bus.ready_o), 64'd0);
        chk("reset.busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_op("divu_100_7", 1'b0, 32'd100, 32'd7);
        chk("divu_100_7.const", bus.result_o, {32'd2, 32'd14});
        // Ready drops on the edge that accepts the next op (back-to-back)
        do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2.const", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
        chk("div_7_m2.const", bus.result_o, {32'h0000_0001, 32'hFFFF_FFFD});
        do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_m1.const", bus.result_o, {32'h0, 32'h8000_0000});
        do_op("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divu_min_m1.const", bus.result_o, {32'h8000_0000, 32'h0});
        @(posedge clk);
        #1;
        chk("ready_one_cycle", 64'(bus.ready_o), 64'd0);
        do_op("divu_5_0", 1'b0, 32'd5, 32'd0);
        do_op("divu_100_7b", 1'b0, 32'd100, 32'd7);

        // Annul mid-flight: no ready, result held
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.dividend_i = 32'd100; bus.divisor_i = 32'd7;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        begin
            bit seen = 1'b0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (bus.ready_o) seen = 1'b1;
            end
            bus.annul_i = 1'b1;
            @(posedge clk);
            #1;
            bus.annul_i = 1'b0;
            chk("annul.busy", 64'(bus.busy_o), 64'd0);
            repeat (30) begin
                @(posedge clk);
                #1;
                if (bus.ready_o) seen = 1'b1;
            end
            chk("annul.no_ready", 64'(seen), 64'd0);
            chk("annul.res_held", bus.result_o, last_res);
        end
        do_op("after_annul", 1'b1, 32'hFFFF_FF00, 32'd3);

        // Synchronous reset mid-operation
        bus.start_i = 1'b1; bus.signed_i = 1'b0;
        bus.dividend_i = 32'd1000; bus.divisor_i = 32'd9;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst.res", bus.result_o, 64'd0);
        chk("midrst.busy", 64'(bus.busy_o), 64'd0);
        begin
            bit seen = 1'b0;
            repeat (20) begin
                @(posedge clk);
                #1;
                if (bus.ready_o) seen = 1'b1;
            end
            chk("midrst.no_ready", 64'(seen), 64'd0);
        end

        do_op("divu_0_9", 1'b0, 32'd0, 32'd9);

        // Random operands, with biased small divisors, zero divisors and zero dividends
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            bit sgn;
            sgn = 1'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'($signed(-$urandom_range(1, 15)));
                2: b = 32'd0;
                3: a = 32'd0;
                default: ;
            endcase
            do_op($sformatf("rand%0d", i), sgn, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
